// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM encoding and counter sizing.
package uart_pkg;

    localparam int unsigned OVERSAMPLE_DEF = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    // Bits needed to count 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// Multi-stage synchroniser for an asynchronous input pin; resets to the idle-high level.
module uart_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] stages;

    // Shift the raw pin through the flop chain; the last stage is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stages <= '1;
        end else begin
            stages <= {stages[SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_16x.sv
// UART receiver driven by a 16x oversampling strobe, with a valid/ready holding register.
module uart_rx_16x
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned OVERSAMPLE  = OVERSAMPLE_DEF,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick_16x,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned TW = cnt_width(OVERSAMPLE);
    localparam int unsigned BW = cnt_width(DATA_BITS);
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    state_t               state, state_nxt;
    logic [TW-1:0]        tick_cnt, tick_cnt_nxt;
    logic [BW-1:0]        bit_cnt, bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift_reg, shift_nxt;
    logic [DATA_BITS-1:0] rx_data_nxt;
    logic                 rx_valid_nxt, frame_err_nxt, overrun_nxt, busy_nxt;
    logic                 rx_s;
    logic                 half_end, bit_end;

    uart_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (rx),
        .q     (rx_s)
    );

    // Tick that lands on the start-bit centre, and tick that ends a full bit period.
    assign half_end = tick_16x && (tick_cnt == HALF_LAST);
    assign bit_end  = tick_16x && (tick_cnt == FULL_LAST);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decisions, all taken on tick cycles from the synchronised line.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (tick_16x && !rx_s) state_nxt = ST_START;
            ST_START: if (half_end) state_nxt = rx_s ? ST_IDLE : ST_DATA;
            ST_DATA:  if (bit_end && (bit_cnt == BIT_LAST)) state_nxt = ST_STOP;
            ST_STOP:  if (bit_end) state_nxt = rx_s ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (tick_16x && rx_s) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Counter, shifter and holding-register updates; flags are single-cycle pulses.
    always_comb begin
        tick_cnt_nxt  = tick_cnt;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_reg;
        rx_data_nxt   = rx_data;
        rx_valid_nxt  = rx_valid && !rx_ready;
        frame_err_nxt = 1'b0;
        overrun_nxt   = 1'b0;
        busy_nxt      = (state_nxt != ST_IDLE);
        unique case (state)
            ST_IDLE: begin
                if (tick_16x && !rx_s) begin
                    tick_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                end
            end
            ST_START: begin
                if (half_end) begin
                    tick_cnt_nxt = '0;
                    bit_cnt_nxt  = '0;
                end else if (tick_16x) begin
                    tick_cnt_nxt = tick_cnt + TW'(1);
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_nxt    = {rx_s, shift_reg[DATA_BITS-1:1]};
                    tick_cnt_nxt = '0;
                    bit_cnt_nxt  = bit_cnt + BW'(1);
                end else if (tick_16x) begin
                    tick_cnt_nxt = tick_cnt + TW'(1);
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    tick_cnt_nxt = '0;
                    if (!rx_s) begin
                        frame_err_nxt = 1'b1;
                    end else if (!rx_valid || rx_ready) begin
                        rx_data_nxt  = shift_reg;
                        rx_valid_nxt = 1'b1;
                    end else begin
                        overrun_nxt = 1'b1;
                    end
                end else if (tick_16x) begin
                    tick_cnt_nxt = tick_cnt + TW'(1);
                end
            end
            ST_BREAK: begin
                tick_cnt_nxt = tick_cnt;
            end
            default: begin
                tick_cnt_nxt = '0;
                bit_cnt_nxt  = '0;
            end
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            tick_cnt  <= tick_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            shift_reg <= shift_nxt;
            rx_data   <= rx_data_nxt;
            rx_valid  <= rx_valid_nxt;
            frame_err <= frame_err_nxt;
            overrun   <= overrun_nxt;
            busy      <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_uart_rx_16x.sv
// Self-checking bench for uart_rx_16x: frame table, hand-built corner cases, random frames.
module tb_uart_rx_16x;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       rx       = 1'b1;
    logic       rx_ready = 1'b0;
    logic       tick_16x;
    logic [7:0] rx_data;
    logic       rx_valid, frame_err, overrun, busy;
    logic [3:0] div = 4'd0;

    int vectors     = 0;
    int miscompares = 0;

    // Observed traffic, sampled mid-low-phase so inputs driven at negedge are settled.
    int         n_acc  = 0;
    int         n_ferr = 0;
    int         n_ovr  = 0;
    logic [7:0] last_acc = 8'h00;
    bit         valid_fell = 1'b0;
    logic       prev_valid = 1'b0;
    logic [7:0] acc_q[$];

    typedef struct {
        logic [7:0] data;
        bit         stop_ok;
        bit         ready;
        int         exp_acc;
        logic [7:0] exp_acc_data;
        bit         exp_valid;
        logic [7:0] exp_hold;
        int         exp_ferr;
        int         exp_ovr;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    // 16x strobe: one clk high out of every ten.
    always @(posedge clk) div <= (div == 4'd9) ? 4'd0 : div + 4'd1;
    assign tick_16x = (div == 4'd9);

    uart_rx_16x dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_16x  (tick_16x),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always begin
        @(negedge clk);
        #2;
        if (rx_valid && rx_ready) begin
            n_acc++;
            last_acc = rx_data;
            acc_q.push_back(rx_data);
        end
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
        if (prev_valid && !rx_valid) valid_fell = 1'b1;
        prev_valid = rx_valid;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Return at the negedge inside the n-th following tick cycle.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (tick_16x !== 1'b1) @(negedge clk);
        end
    endtask

    task automatic clear_obs();
        n_acc      = 0;
        n_ferr     = 0;
        n_ovr      = 0;
        valid_fell = 1'b0;
        acc_q.delete();
    endtask

    // Start bit, data LSB first, then the stop level; leaves the stop level on the line.
    task automatic send_bits(input logic [7:0] d, input bit stop_ok);
        wait_ticks(1);
        rx = 1'b0;
        for (int j = 0; j < 8; j++) begin
            wait_ticks(16);
            rx = d[j];
        end
        wait_ticks(16);
        rx = stop_ok;
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok);
        send_bits(d, stop_ok);
        wait_ticks(16);
        rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rx_data"},   32'(rx_data),   32'h0);
        check({tag, " rx_valid"},  32'(rx_valid),  32'h0);
        check({tag, " frame_err"}, 32'(frame_err), 32'h0);
        check({tag, " overrun"},   32'(overrun),   32'h0);
        check({tag, " busy"},      32'(busy),      32'h0);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int         exp_ferr;
        logic [7:0] d;
        bit         ok;
        int         gap;

        vecs[0] = '{8'hA5, 1'b1, 1'b1, 1, 8'hA5, 1'b0, 8'h00, 0, 0};
        vecs[1] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 1'b0, 8'h00, 0, 0};
        vecs[2] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 1'b0, 8'h00, 0, 0};
        vecs[3] = '{8'h3C, 1'b0, 1'b1, 0, 8'h00, 1'b0, 8'h00, 1, 0};
        vecs[4] = '{8'h96, 1'b1, 1'b1, 1, 8'h96, 1'b0, 8'h00, 0, 0};
        vecs[5] = '{8'h11, 1'b1, 1'b0, 0, 8'h00, 1'b1, 8'h11, 0, 0};
        vecs[6] = '{8'h22, 1'b1, 1'b0, 0, 8'h00, 1'b1, 8'h11, 0, 1};

        // Power-on reset values.
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        wait_ticks(20);

        // Table of whole frames.
        for (int i = 0; i < 7; i++) begin
            rx_ready = vecs[i].ready;
            clear_obs();
            send_frame(vecs[i].data, vecs[i].stop_ok);
            wait_ticks(6);
            check($sformatf("vec%0d accepted", i), 32'(n_acc), 32'(vecs[i].exp_acc));
            if (vecs[i].exp_acc > 0)
                check($sformatf("vec%0d acc_data", i), 32'(last_acc), 32'(vecs[i].exp_acc_data));
            check($sformatf("vec%0d rx_valid", i), 32'(rx_valid), 32'(vecs[i].exp_valid));
            if (vecs[i].exp_valid)
                check($sformatf("vec%0d rx_data", i), 32'(rx_data), 32'(vecs[i].exp_hold));
            check($sformatf("vec%0d frame_err", i), 32'(n_ferr), 32'(vecs[i].exp_ferr));
            check($sformatf("vec%0d overrun", i), 32'(n_ovr), 32'(vecs[i].exp_ovr));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'h0);
        end

        // Raising rx_ready drains the held byte on the next clk.
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("handshake clear", 32'(rx_valid), 32'h0);

        // Short low glitch: start check at the centre tick rejects it.
        clear_obs();
        wait_ticks(1);
        rx = 1'b0;
        wait_ticks(3);
        check("glitch busy early", 32'(busy), 32'h1);
        wait_ticks(1);
        rx = 1'b1;
        wait_ticks(4);
        check("glitch busy before centre", 32'(busy), 32'h1);
        wait_ticks(2);
        check("glitch busy after centre", 32'(busy), 32'h0);
        check("glitch rx_valid", 32'(rx_valid), 32'h0);
        check("glitch frame_err", 32'(n_ferr), 32'h0);

        // Bad stop followed by a held-low line: one frame error, busy until release.
        rx_ready = 1'b1;
        clear_obs();
        send_bits(8'h3C, 1'b0);
        wait_ticks(16 + 48);
        check("break busy", 32'(busy), 32'h1);
        check("break frame_err", 32'(n_ferr), 32'h1);
        check("break rx_valid", 32'(rx_valid), 32'h0);
        check("break accepted", 32'(n_acc), 32'h0);
        rx = 1'b1;
        wait_ticks(4);
        check("break busy released", 32'(busy), 32'h0);
        check("break frame_err total", 32'(n_ferr), 32'h1);

        // Completion in the same cycle the previous byte is accepted.
        rx_ready = 1'b0;
        send_frame(8'h0F, 1'b1);
        wait_ticks(6);
        check("held 0x0F", 32'(rx_data), 32'h0F);
        clear_obs();
        fork
            send_frame(8'h55, 1'b1);
            begin
                wait_ticks(1);
                wait_ticks(153);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end
        join
        wait_ticks(6);
        check("same-cycle rx_valid", 32'(rx_valid), 32'h1);
        check("same-cycle rx_data", 32'(rx_data), 32'h55);
        check("same-cycle overrun", 32'(n_ovr), 32'h0);
        check("same-cycle valid continuous", 32'(valid_fell), 32'h0);
        check("same-cycle accepted", 32'(n_acc), 32'h1);
        check("same-cycle acc_data", 32'(last_acc), 32'h0F);
        rx_ready = 1'b1;
        @(negedge clk);

        // Reset in the middle of 0xFF, then a clean 0x81.
        wait_ticks(1);
        rx = 1'b0;
        for (int j = 0; j < 4; j++) begin
            wait_ticks(16);
            rx = 1'b1;
        end
        wait_ticks(24);
        check("midframe busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("midreset");
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(32);
        clear_obs();
        send_frame(8'h81, 1'b1);
        wait_ticks(6);
        check("post-reset accepted", 32'(n_acc), 32'h1);
        check("post-reset data", 32'(last_acc), 32'h81);
        check("post-reset frame_err", 32'(n_ferr), 32'h0);
        check("post-reset overrun", 32'(n_ovr), 32'h0);

        // Random frames against a frame-level model: good stop delivers, bad stop flags.
        rx_ready = 1'b1;
        clear_obs();
        exp_ferr = 0;
        for (int k = 0; k < 12; k++) begin
            d   = 8'($urandom);
            ok  = ($urandom_range(0, 4) != 0);
            gap = ok ? int'($urandom_range(0, 20)) : int'($urandom_range(4, 20));
            send_frame(d, ok);
            if (ok) exp_q.push_back(d);
            else    exp_ferr++;
            wait_ticks(gap);
        end
        wait_ticks(6);
        check("rand byte count", 32'(acc_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < acc_q.size(); k++)
            check($sformatf("rand byte %0d", k), 32'(acc_q[k]), 32'(exp_q[k]));
        check("rand frame_err", 32'(n_ferr), 32'(exp_ferr));
        check("rand overrun", 32'(n_ovr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
